// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC cycle decoder: FSM states, CYCTYPE
// classes, SYNC codes and the START code.
package lpc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_ADDR  = 3'd2,
      ST_WDATA = 3'd3,
      ST_TAR   = 3'd4,
      ST_SYNC  = 3'd5,
      ST_RDATA = 3'd6
   } lpc_state_t;

   localparam logic [1:0] CYC_IO  = 2'b00;
   localparam logic [1:0] CYC_MEM = 2'b01;

   localparam logic [3:0] SYNC_READY      = 4'b0000;
   localparam logic [3:0] SYNC_SHORT_WAIT = 4'b0101;
   localparam logic [3:0] SYNC_LONG_WAIT  = 4'b0110;
   localparam logic [3:0] SYNC_ERROR      = 4'b1010;

   localparam logic [3:0] START_CODE = 4'b0000;

   // True for either of the two SYNC wait codes.
   function automatic logic is_wait_sync(input logic [3:0] ad);
      return (ad == SYNC_SHORT_WAIT) || (ad == SYNC_LONG_WAIT);
   endfunction

endpackage

// File: rtl/lpc_cycle_decoder.sv
// Passive LPC snooper: decodes I/O and memory read/write cycles from
// LAD/LFRAME#, follows SYNC waits, and reports one record per completed
// cycle plus abort and timeout pulses.
module lpc_cycle_decoder
   import lpc_pkg::*;
#(
   parameter int ENABLE_IO    = 1,
   parameter int ENABLE_MEM   = 1,
   parameter int SYNC_TIMEOUT = 255
) (
   input  logic        lpc_clock,
   input  logic        lpc_reset,
   input  logic [3:0]  lpc_ad,
   input  logic        lpc_frame,
   output logic [3:0]  out_cyctype_dir,
   output logic [31:0] out_addr,
   output logic [7:0]  out_data,
   output logic        out_valid,
   output logic        out_sync_err,
   output logic        out_timeout,
   output logic        out_abort
);

   localparam int WCW = $clog2(SYNC_TIMEOUT + 1);
   // Wait count value at which the next wait nibble is the last one allowed.
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(SYNC_TIMEOUT - 1);

   lpc_state_t     r_state;
   logic [2:0]     r_nib_cnt;
   logic [WCW-1:0] r_wait_cnt;
   logic [3:0]     r_cyctype;
   logic [31:0]    r_addr_sh;
   logic [7:0]     r_data_sh;
   logic           r_sync_err;

   logic [3:0]     r_out_cyctype_dir;
   logic [31:0]    r_out_addr;
   logic [7:0]     r_out_data;
   logic           r_out_valid;
   logic           r_out_sync_err;
   logic           r_out_timeout;
   logic           r_out_abort;

   logic           w_type_ok;
   logic           w_addr_last;
   logic           w_in_cycle;

   // CYCTYPE accepted only for classes enabled by parameter.
   assign w_type_ok = ((lpc_ad[3:2] == CYC_IO)  && (ENABLE_IO  != 0)) ||
                      ((lpc_ad[3:2] == CYC_MEM) && (ENABLE_MEM != 0));

   // Memory cycles carry 8 address nibbles, I/O cycles 4.
   assign w_addr_last = r_cyctype[2] ? (r_nib_cnt == 3'd7) : (r_nib_cnt == 3'd3);

   // LFRAME# low in these states kills the cycle in progress.
   assign w_in_cycle = (r_state == ST_ADDR) || (r_state == ST_WDATA) ||
                       (r_state == ST_TAR)  || (r_state == ST_SYNC)  ||
                       (r_state == ST_RDATA);

   // Cycle FSM with registered record and pulse outputs.
   always_ff @(posedge lpc_clock) begin
      if (lpc_reset) begin
         r_state           <= ST_IDLE;
         r_nib_cnt         <= 3'd0;
         r_wait_cnt        <= '0;
         r_cyctype         <= 4'd0;
         r_addr_sh         <= 32'd0;
         r_data_sh         <= 8'd0;
         r_sync_err        <= 1'b0;
         r_out_cyctype_dir <= 4'd0;
         r_out_addr        <= 32'd0;
         r_out_data        <= 8'd0;
         r_out_valid       <= 1'b0;
         r_out_sync_err    <= 1'b0;
         r_out_timeout     <= 1'b0;
         r_out_abort       <= 1'b0;
      end else begin
         r_out_valid   <= 1'b0;
         r_out_timeout <= 1'b0;
         r_out_abort   <= 1'b0;
         if (w_in_cycle && !lpc_frame) begin
            r_out_abort <= 1'b1;
            r_state     <= (lpc_ad == START_CODE) ? ST_START : ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (!lpc_frame && (lpc_ad == START_CODE)) begin
                     r_state <= ST_START;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
               ST_START: begin
                  if (!lpc_frame) begin
                     r_state <= (lpc_ad == START_CODE) ? ST_START : ST_IDLE;
                  end else begin
                     r_cyctype <= lpc_ad;
                     if (w_type_ok) begin
                        r_state    <= ST_ADDR;
                        r_nib_cnt  <= 3'd0;
                        r_addr_sh  <= 32'd0;
                        r_data_sh  <= 8'd0;
                        r_sync_err <= 1'b0;
                     end else begin
                        r_state <= ST_IDLE;
                     end
                  end
               end
               ST_ADDR: begin
                  r_addr_sh <= {r_addr_sh[27:0], lpc_ad};
                  if (w_addr_last) begin
                     r_nib_cnt <= 3'd0;
                     r_state   <= r_cyctype[1] ? ST_WDATA : ST_TAR;
                  end else begin
                     r_nib_cnt <= r_nib_cnt + 3'd1;
                  end
               end
               ST_WDATA: begin
                  if (r_nib_cnt[0] == 1'b0) begin
                     r_data_sh[3:0] <= lpc_ad;
                     r_nib_cnt      <= 3'd1;
                  end else begin
                     r_data_sh[7:4] <= lpc_ad;
                     r_nib_cnt      <= 3'd0;
                     r_state        <= ST_TAR;
                  end
               end
               ST_TAR: begin
                  if (r_nib_cnt[0] == 1'b0) begin
                     r_nib_cnt <= 3'd1;
                  end else begin
                     r_nib_cnt  <= 3'd0;
                     r_wait_cnt <= '0;
                     r_state    <= ST_SYNC;
                  end
               end
               ST_SYNC: begin
                  if ((lpc_ad == SYNC_READY) || (lpc_ad == SYNC_ERROR)) begin
                     if (r_cyctype[1]) begin
                        r_out_cyctype_dir <= r_cyctype;
                        r_out_addr        <= r_addr_sh;
                        r_out_data        <= r_data_sh;
                        r_out_sync_err    <= (lpc_ad == SYNC_ERROR);
                        r_out_valid       <= 1'b1;
                        r_state           <= ST_IDLE;
                     end else begin
                        r_sync_err <= (lpc_ad == SYNC_ERROR);
                        r_nib_cnt  <= 3'd0;
                        r_state    <= ST_RDATA;
                     end
                  end else if (is_wait_sync(lpc_ad)) begin
                     if (r_wait_cnt == WAIT_LAST) begin
                        r_out_timeout <= 1'b1;
                        r_state       <= ST_IDLE;
                     end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                     end
                  end else begin
                     r_out_abort <= 1'b1;
                     r_state     <= ST_IDLE;
                  end
               end
               ST_RDATA: begin
                  if (r_nib_cnt[0] == 1'b0) begin
                     r_data_sh[3:0] <= lpc_ad;
                     r_nib_cnt      <= 3'd1;
                  end else begin
                     r_out_cyctype_dir <= r_cyctype;
                     r_out_addr        <= r_addr_sh;
                     r_out_data        <= {lpc_ad, r_data_sh[3:0]};
                     r_out_sync_err    <= r_sync_err;
                     r_out_valid       <= 1'b1;
                     r_nib_cnt         <= 3'd0;
                     r_state           <= ST_IDLE;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign out_cyctype_dir = r_out_cyctype_dir;
   assign out_addr        = r_out_addr;
   assign out_data        = r_out_data;
   assign out_valid       = r_out_valid;
   assign out_sync_err    = r_out_sync_err;
   assign out_timeout     = r_out_timeout;
   assign out_abort       = r_out_abort;

endmodule
